// File: rtl/boxhead_gfx_pkg.sv
// Shared graphics definitions for the boxhead frame-buffer path: screen
// geometry, pixel/coordinate widths and the sprite blitter state encoding.
package boxhead_gfx_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int COLOR_W  = 16;
    localparam int DIM_W    = 7;   // sprite width/height, 0..64

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        DRAW  = 2'd2
    } blit_state_e;

endpackage

// File: rtl/blit_pixel_qual.sv
// Per-pixel screen position and write qualification for the sprite blitter.
// Sums are one bit wider than a coordinate so that a wrap past 1023 lands
// off-screen instead of aliasing back onto the visible area.
module blit_pixel_qual
    import boxhead_gfx_pkg::*;
(
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [DIM_W-1:0]   col_i,
    input  logic [DIM_W-1:0]   row_i,
    input  logic [COLOR_W-1:0] data_i,
    input  logic [COLOR_W-1:0] key_i,
    output logic [COORD_W:0]   x_sum_o,
    output logic [COORD_W:0]   y_sum_o,
    output logic               write_o
);

    localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H);

    // Screen position of the current sprite pixel, then clip and colour-key test.
    always_comb begin
        x_sum_o = {1'b0, x0_i} + {{(COORD_W+1-DIM_W){1'b0}}, col_i};
        y_sum_o = {1'b0, y0_i} + {{(COORD_W+1-DIM_W){1'b0}}, row_i};
        write_o = (data_i != key_i) && (x_sum_o < X_LIM) && (y_sum_o < Y_LIM);
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: accepts a rectangular draw command, walks the sprite ROM
// row-major and loads one pixel per controller write slot onto program_*.
//
//   state | meaning
//   IDLE  | ready for a command; slot edges present program_write = 0
//   PRIME | one cycle while the ROM registers the base address
//   DRAW  | one pixel loaded per slot_tick edge until the last pixel
module sprite_blitter
    import boxhead_gfx_pkg::*;
#(
    parameter int ROM_AW = 16
) (
    input  logic                sram_clk,
    input  logic                reset,
    input  logic                slot_tick,
    input  logic                frame_start,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [COORD_W-1:0]  cmd_x,
    input  logic [COORD_W-1:0]  cmd_y,
    input  logic [DIM_W-1:0]    cmd_w,
    input  logic [DIM_W-1:0]    cmd_h,
    input  logic [ROM_AW-1:0]   cmd_base,
    input  logic [COLOR_W-1:0]  cmd_key,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [COLOR_W-1:0]  rom_data,
    output logic [COORD_W-1:0]  program_x,
    output logic [COORD_W-1:0]  program_y,
    output logic [COLOR_W-1:0]  program_data,
    output logic                program_write,
    output logic                busy,
    output logic                overrun
);

    blit_state_e        state_q, state_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]   col_q, col_d, row_q, row_d;
    logic [COLOR_W-1:0] key_q, key_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic [COLOR_W-1:0] pdata_q, pdata_d;
    logic               pwrite_q, pwrite_d;
    logic               overrun_q, overrun_d;

    logic [COORD_W:0]   x_sum, y_sum;
    logic               qual_write;
    logic               last_col, last_row;

    blit_pixel_qual u_qual (
        .x0_i    (x0_q),
        .y0_i    (y0_q),
        .col_i   (col_q),
        .row_i   (row_q),
        .data_i  (rom_data),
        .key_i   (key_q),
        .x_sum_o (x_sum),
        .y_sum_o (y_sum),
        .write_o (qual_write)
    );

    assign last_col = (col_q == (w_q - 7'd1));
    assign last_row = (row_q == (h_q - 7'd1));

    // Next-state logic: command capture, pixel load/advance and frame abort.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        key_d      = key_q;
        col_d      = col_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        px_d       = px_q;
        py_d       = py_q;
        pdata_d    = pdata_q;
        pwrite_d   = pwrite_q;
        overrun_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (slot_tick) pwrite_d = 1'b0;
                if (cmd_valid) begin
                    x0_d       = cmd_x;
                    y0_d       = cmd_y;
                    w_d        = cmd_w;
                    h_d        = cmd_h;
                    key_d      = cmd_key;
                    rom_addr_d = cmd_base;
                    col_d      = '0;
                    row_d      = '0;
                    // Zero-area sprites are swallowed without leaving IDLE.
                    if ((cmd_w != '0) && (cmd_h != '0)) state_d = PRIME;
                end
            end
            PRIME: begin
                if (frame_start) begin
                    state_d   = IDLE;
                    pwrite_d  = 1'b0;
                    overrun_d = 1'b1;
                end else begin
                    state_d = DRAW;
                    if (slot_tick) pwrite_d = 1'b0;
                end
            end
            DRAW: begin
                if (frame_start) begin
                    state_d   = IDLE;
                    pwrite_d  = 1'b0;
                    overrun_d = 1'b1;
                end else if (slot_tick) begin
                    px_d       = x_sum[COORD_W-1:0];
                    py_d       = y_sum[COORD_W-1:0];
                    pdata_d    = rom_data;
                    pwrite_d   = qual_write;
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) state_d = IDLE;
                        else          row_d   = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sram_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            key_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rom_addr_q <= '0;
            px_q       <= '0;
            py_q       <= '0;
            pdata_q    <= '0;
            pwrite_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            key_q      <= key_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr_d;
            px_q       <= px_d;
            py_q       <= py_d;
            pdata_q    <= pdata_d;
            pwrite_q   <= pwrite_d;
            overrun_q  <= overrun_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign rom_addr      = rom_addr_q;
    assign program_x     = px_q;
    assign program_y     = py_q;
    assign program_data  = pdata_q;
    assign program_write = pwrite_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: the stimulus side expands each command
// into its expected pixel list from the sprite's geometry and ROM contents;
// the monitor pops one entry per pixel-load slot edge and compares.
module tb_sprite_blitter;

    localparam int ROM_AW = 16;

    logic              sram_clk = 1'b0;
    logic              reset = 1'b1;
    logic              slot_tick = 1'b0;
    logic              frame_start = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [9:0]        cmd_x = '0, cmd_y = '0;
    logic [6:0]        cmd_w = '0, cmd_h = '0;
    logic [ROM_AW-1:0] cmd_base = '0;
    logic [15:0]       cmd_key = '0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [9:0]        program_x, program_y;
    logic [15:0]       program_data;
    logic              program_write, busy, overrun;

    sprite_blitter #(.ROM_AW(ROM_AW)) dut (
        .sram_clk(sram_clk), .reset(reset), .slot_tick(slot_tick),
        .frame_start(frame_start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_base(cmd_base), .cmd_key(cmd_key), .rom_addr(rom_addr),
        .rom_data(rom_data), .program_x(program_x), .program_y(program_y),
        .program_data(program_data), .program_write(program_write),
        .busy(busy), .overrun(overrun)
    );

    always #5 sram_clk = ~sram_clk;

    // Synchronous sprite ROM model.
    logic [15:0] rom_mem [0:65535];
    always @(posedge sram_clk) rom_data <= rom_mem[rom_addr];

    // Controller write slots: every other cycle.
    initial forever begin
        @(posedge sram_clk); #2;
        slot_tick = ~slot_tick;
    end

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
        logic        w;
        bit          last;
    } pix_t;
    pix_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: expand a command into its pixel list.
    task automatic model_cmd(input int x, input int y, input int w, input int h,
                             input int base, input logic [15:0] key);
        if (w == 0 || h == 0) return;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                pix_t p;
                logic [15:0] a;
                int xs, ys;
                a  = 16'(base + r * w + c);
                xs = x + c;
                ys = y + r;
                p.x    = 10'(xs);
                p.y    = 10'(ys);
                p.d    = rom_mem[a];
                p.w    = (rom_mem[a] != key) && (xs < 640) && (ys < 480);
                p.last = (r == h - 1) && (c == w - 1);
                exp_q.push_back(p);
            end
        end
    endtask

    // Monitor: classify each edge from the inputs/busy seen just before it.
    initial begin
        bit pb, pb2, ps, pf, pr;
        pb = 0; pb2 = 0;
        forever begin
            @(negedge sram_clk);
            pb2 = pb;
            pb  = busy;
            ps  = slot_tick;
            pf  = frame_start;
            pr  = reset;
            @(posedge sram_clk); #1;
            if (pr) begin
                chk("rst_write", 32'(program_write), 0);
                chk("rst_x", 32'(program_x), 0);
                chk("rst_y", 32'(program_y), 0);
                chk("rst_data", 32'(program_data), 0);
                chk("rst_ready", 32'(cmd_ready), 1);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_overrun", 32'(overrun), 0);
                chk("rst_rom_addr", 32'(rom_addr), 0);
                exp_q.delete();
            end else if (pb && pf) begin
                chk("abort_overrun", 32'(overrun), 1);
                chk("abort_write", 32'(program_write), 0);
                chk("abort_ready", 32'(cmd_ready), 1);
                exp_q.delete();
            end else if (pb && pb2 && ps) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_pixel_load");
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("pix_x", 32'(program_x), 32'(e.x));
                    chk("pix_y", 32'(program_y), 32'(e.y));
                    chk("pix_data", 32'(program_data), 32'(e.d));
                    chk("pix_write", 32'(program_write), 32'(e.w));
                    chk("pix_overrun", 32'(overrun), 0);
                    if (e.last) chk("ready_after_last", 32'(cmd_ready), 1);
                end
            end else if (ps) begin
                chk("idle_slot_write", 32'(program_write), 0);
                chk("idle_slot_overrun", 32'(overrun), 0);
            end else begin
                chk("no_overrun", 32'(overrun), 0);
            end
        end
    end

    task automatic tick();
        @(posedge sram_clk); #3;
    endtask

    task automatic issue(input int x, input int y, input int w, input int h,
                         input int base, input logic [15:0] key, input bit fs_with);
        int n;
        n = 0;
        while (!cmd_ready && n < 3000) begin tick(); n++; end
        if (n >= 3000) fail_now("timeout_waiting_ready");
        model_cmd(x, y, w, h, base, key);
        cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 7'(w); cmd_h = 7'(h);
        cmd_base = 16'(base); cmd_key = key;
        cmd_valid = 1'b1;
        frame_start = fs_with;
        tick();
        cmd_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 3000) begin tick(); n++; end
        if (n >= 3000) fail_now("timeout_waiting_done");
    endtask

    task automatic wait_left(input int left);
        int n;
        n = 0;
        while (!(exp_q.size() <= left && slot_tick) && n < 3000) begin tick(); n++; end
        if (n >= 3000) fail_now("timeout_waiting_pixels");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) rom_mem[i] = 16'($urandom);
        rom_mem[16'h100] = 16'hA0A0; rom_mem[16'h101] = 16'hB1B1;
        rom_mem[16'h102] = 16'hC2C2; rom_mem[16'h103] = 16'hD3D3;
        rom_mem[16'h200] = 16'h1234; rom_mem[16'h201] = 16'h5678;
        rom_mem[16'h202] = 16'h1234;
        for (int i = 0; i < 8; i++) rom_mem[16'h300 + i] = 16'h0F00 + 16'(i);

        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Basic 2x2
        issue(10, 20, 2, 2, 16'h100, 16'h0001, 0);
        wait_done();
        repeat (4) tick();

        // Transparency 3x1
        issue(100, 50, 3, 1, 16'h200, 16'h1234, 0);
        wait_done();

        // Clipping at the bottom-right corner
        issue(638, 479, 4, 2, 16'h300, 16'hFFFF, 0);
        wait_done();

        // Zero-size command
        issue(5, 5, 0, 3, 16'h700, 16'h0000, 0);
        chk("zero_ready", 32'(cmd_ready), 1);
        chk("zero_busy", 32'(busy), 0);
        repeat (3) begin
            tick();
            chk("zero_busy_later", 32'(busy), 0);
        end

        // Full-width row boundary
        issue(0, 0, 64, 2, 16'h800, 16'h0000, 0);
        wait_done();

        // Frame abort after pixel 10, coincident with a slot tick
        issue(0, 0, 8, 8, 16'h400, 16'h0000, 0);
        wait_left(54);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("abort_idle", 32'(cmd_ready), 1);
        repeat (6) tick();

        // Reset mid-DRAW, then a command from its own base
        issue(30, 40, 8, 8, 16'h500, 16'h0000, 0);
        wait_left(50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        issue(60, 70, 3, 2, 16'h600, 16'h0000, 0);
        wait_done();

        // Randomized commands
        for (int k = 0; k < 25; k++) begin
            int x, y, w, h, base;
            logic [15:0] key;
            x = ($urandom_range(0, 1) == 1) ? $urandom_range(600, 1023) : $urandom_range(0, 639);
            y = ($urandom_range(0, 1) == 1) ? $urandom_range(460, 1023) : $urandom_range(0, 479);
            w = $urandom_range(0, 8);
            h = $urandom_range(0, 6);
            base = $urandom_range(0, 65535);
            key = ($urandom_range(0, 1) == 1) ? rom_mem[16'(base)] : 16'($urandom);
            issue(x, y, w, h, base, key, ($urandom_range(0, 3) == 0));
            wait_done();
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (10) tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
